lc_egress_frame_buffer: RTL and testbench

Store-and-forward egress buffer for one line-card transmit port, in the `clk_fabric` domain between the switch fabric's forwarding output and the per-port transmit CDC. Frames arriving from the fabric are written into a local RAM and only become visible to the transmit side once the final word has arrived without error. Frames that do not fit, or that the fabric flags as bad, are discarded whole and counted. The fabric is never backpressured.

---
 rtl/egress_pkg.sv | 32 +++
 rtl/egress_sdp_ram.sv | 27 ++
 rtl/lc_egress_frame_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_lc_egress_frame_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/egress_pkg.sv
// Shared types for the line-card egress frame buffer.
//   frame_words_t : per-frame word count, wide enough for a frame of EGR_MAX_DEPTH words
//   meta_t        : one committed-frame descriptor held in the metadata FIFO
//   wr_state_e    : fabric-side write FSM states
//   rd_state_e    : transmit-side read FSM states
//   sat_inc       : 32-bit saturating increment for the statistics counters
package egress_pkg;

  localparam int unsigned EGR_MAX_DEPTH = 1024;

  typedef logic [$clog2(EGR_MAX_DEPTH):0] frame_words_t;

  typedef struct packed {
    frame_words_t words;
  } meta_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACTIVE,
    WR_DROP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/egress_sdp_ram.sv
// Simple dual-port RAM, one write port and one read port with a registered
// (1-cycle) read. The read register holds its value while i_re is low.
//   clk      : clock
//   i_we     : write enable;  i_waddr / i_wdata : write address / data
//   i_re     : read enable;   i_raddr : read address
//   o_rdata  : read data, valid the cycle after i_re
module egress_sdp_ram #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/lc_egress_frame_buffer.sv
// Store-and-forward egress buffer for one line-card transmit port.
// Fabric words are written to a local RAM; a frame becomes visible to the
// transmit side only after its last word arrives good. Oversized, bad or
// unplaceable frames are discarded whole. The fabric is never backpressured.
//   clk_fabric, rst_n         : clock, async active-low reset
//   fab_t*                    : fabric AXI-Stream input (tuser=1 with tlast marks bad frame)
//   tx_t*                     : transmit AXI-Stream output
//   frames_sent/frames_dropped: saturating statistics
module lc_egress_frame_buffer
  import egress_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = EGR_MAX_DEPTH,
  parameter int unsigned MAX_FRAMES = 64
) (
  input  logic                    clk_fabric,
  input  logic                    rst_n,
  input  logic                    fab_tvalid,
  output logic                    fab_tready,
  input  logic [DATA_WIDTH-1:0]   fab_tdata,
  input  logic [DATA_WIDTH/8-1:0] fab_tkeep,
  input  logic                    fab_tlast,
  input  logic                    fab_tuser,
  output logic                    tx_tvalid,
  input  logic                    tx_tready,
  output logic [DATA_WIDTH-1:0]   tx_tdata,
  output logic [DATA_WIDTH/8-1:0] tx_tkeep,
  output logic                    tx_tlast,
  output logic [31:0]             frames_sent,
  output logic [31:0]             frames_dropped
);

  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned EW = KW + 1 + DATA_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned MW = $clog2(MAX_FRAMES);
  localparam int unsigned HW = MW + 1;

  typedef logic [PW-1:0] ptr_t;

  wr_state_e    r_wst, w_wst_n;
  ptr_t         r_wr_commit, r_wr_tent, w_wr_commit_n, w_wr_tent_n;
  frame_words_t r_wcnt, w_wcnt_n;
  logic         w_acc, w_we, w_push, w_drop, w_full, w_meta_full;

  rd_state_e    r_rdst, w_rdst_n;
  ptr_t         r_rd_ptr, w_rd_ptr_n;
  frame_words_t r_rem, w_rem_n;
  logic         w_issue, w_pop, w_issue_ok, w_tx_pop, w_tx_done, w_meta_empty;

  meta_t        r_meta [MAX_FRAMES];
  logic [HW-1:0] r_mwp, r_mrp, r_held;

  logic [EW-1:0] w_ram_q, r_skid, w_head;
  logic          r_sv, r_qv, w_q_keep, w_s_keep, r_fab_tready;

  assign fab_tready = r_fab_tready;
  assign w_acc      = fab_tvalid & r_fab_tready;
  // Full check sees the read pointer after this cycle's read issue.
  assign w_full     = (r_wr_tent - w_rd_ptr_n) == ptr_t'(DEPTH);
  // r_held counts committed frames not yet fully transmitted, so a frame
  // parked in the output skid still occupies a descriptor slot.
  assign w_meta_full  = r_held == HW'(MAX_FRAMES);
  assign w_meta_empty = r_mwp == r_mrp;

  // Write FSM. A frame that cannot be placed (no descriptor or no RAM space)
  // is rewound to the last commit point and dropped, even from IDLE.
  always_comb begin
    w_wst_n       = r_wst;
    w_wr_tent_n   = r_wr_tent;
    w_wr_commit_n = r_wr_commit;
    w_wcnt_n      = r_wcnt;
    w_we          = 1'b0;
    w_push        = 1'b0;
    w_drop        = 1'b0;
    unique case (r_wst)
      WR_IDLE, WR_ACTIVE: begin
        if (w_acc) begin
          if (w_full || (r_wst == WR_IDLE && w_meta_full)) begin
            w_wr_tent_n = r_wr_commit;
            w_drop      = fab_tlast;
            w_wst_n     = fab_tlast ? WR_IDLE : WR_DROP;
          end else begin
            w_we        = 1'b1;
            w_wr_tent_n = r_wr_tent + ptr_t'(1);
            w_wcnt_n    = (r_wst == WR_IDLE) ? frame_words_t'(1) : r_wcnt + frame_words_t'(1);
            w_wst_n     = WR_ACTIVE;
            if (fab_tlast) begin
              w_wst_n = WR_IDLE;
              if (fab_tuser) begin
                w_wr_tent_n = r_wr_commit;
                w_drop      = 1'b1;
              end else begin
                w_push        = 1'b1;
                w_wr_commit_n = r_wr_tent + ptr_t'(1);
              end
            end
          end
        end
      end
      WR_DROP: begin
        if (w_acc && fab_tlast) begin
          w_drop  = 1'b1;
          w_wst_n = WR_IDLE;
        end
      end
      default: w_wst_n = WR_IDLE;
    endcase
  end

  // Output holding: the RAM read register is the newer entry, r_skid the older.
  // A new read may only overwrite the RAM register if its word leaves or moves.
  assign tx_tvalid  = r_sv | r_qv;
  assign w_head     = r_sv ? r_skid : w_ram_q;
  assign tx_tdata   = tx_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
  assign tx_tlast   = tx_tvalid & w_head[DATA_WIDTH];
  assign tx_tkeep   = tx_tvalid ? w_head[EW-1 -: KW] : '0;
  assign w_tx_pop   = tx_tvalid & tx_tready;
  assign w_tx_done  = w_tx_pop & w_head[DATA_WIDTH];
  assign w_issue_ok = !(r_sv & r_qv & !w_tx_pop);
  assign w_q_keep   = r_qv & !(w_tx_pop & !r_sv);
  assign w_s_keep   = r_sv & !w_tx_pop;

  // Read FSM. IDLE pops a descriptor and issues its first read in the same
  // cycle; back-to-back frames pass through IDLE without a bubble.
  always_comb begin
    w_rdst_n = r_rdst;
    w_rem_n  = r_rem;
    w_issue  = 1'b0;
    w_pop    = 1'b0;
    unique case (r_rdst)
      RD_IDLE: begin
        if (!w_meta_empty && w_issue_ok) begin
          w_pop    = 1'b1;
          w_issue  = 1'b1;
          w_rem_n  = r_meta[r_mrp[MW-1:0]].words - frame_words_t'(1);
          w_rdst_n = (w_rem_n == '0) ? RD_IDLE : RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (w_issue_ok) begin
          w_issue = 1'b1;
          w_rem_n = r_rem - frame_words_t'(1);
          if (r_rem == frame_words_t'(1)) w_rdst_n = RD_IDLE;
        end
      end
      default: w_rdst_n = RD_IDLE;
    endcase
  end

  assign w_rd_ptr_n = w_issue ? r_rd_ptr + ptr_t'(1) : r_rd_ptr;

  always_ff @(posedge clk_fabric or negedge rst_n) begin
    if (!rst_n) begin
      r_fab_tready   <= 1'b0;
      r_wst          <= WR_IDLE;
      r_wr_commit    <= '0;
      r_wr_tent      <= '0;
      r_wcnt         <= '0;
      r_rdst         <= RD_IDLE;
      r_rd_ptr       <= '0;
      r_rem          <= '0;
      r_mwp          <= '0;
      r_mrp          <= '0;
      r_held         <= '0;
      r_sv           <= 1'b0;
      r_qv           <= 1'b0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      r_fab_tready <= 1'b1;
      r_wst        <= w_wst_n;
      r_wr_commit  <= w_wr_commit_n;
      r_wr_tent    <= w_wr_tent_n;
      r_wcnt       <= w_wcnt_n;
      r_rdst       <= w_rdst_n;
      r_rd_ptr     <= w_rd_ptr_n;
      r_rem        <= w_rem_n;
      if (w_push) r_mwp <= r_mwp + HW'(1);
      if (w_pop)  r_mrp <= r_mrp + HW'(1);
      r_held <= r_held + HW'(w_push) - HW'(w_tx_done);
      r_qv   <= w_issue | w_q_keep;
      r_sv   <= w_s_keep | (w_q_keep & w_issue);
      if (w_drop)    frames_dropped <= sat_inc(frames_dropped);
      if (w_tx_done) frames_sent    <= sat_inc(frames_sent);
    end
  end

  always_ff @(posedge clk_fabric) begin
    if (w_push) r_meta[r_mwp[MW-1:0]] <= '{words: w_wcnt_n};
    if (w_q_keep && w_issue) r_skid <= w_ram_q;
  end

  egress_sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk_fabric),
    .i_we    (w_we),
    .i_waddr (r_wr_tent[AW-1:0]),
    .i_wdata ({fab_tkeep, fab_tlast, fab_tdata}),
    .i_re    (w_issue),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );

endmodule

// File: tb/tb_lc_egress_frame_buffer.sv
// Scoreboard bench for lc_egress_frame_buffer: good frames are queued when
// driven and compared word-by-word as the transmit side hands them over.
module tb_lc_egress_frame_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned KW    = DW / 8;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned MAXF  = 64;

  logic          clk_fabric = 1'b0;
  logic          rst_n = 1'b0;
  logic          fab_tvalid = 1'b0, fab_tready;
  logic [DW-1:0] fab_tdata = '0;
  logic [KW-1:0] fab_tkeep = '0;
  logic          fab_tlast = 1'b0, fab_tuser = 1'b0;
  logic          tx_tvalid, tx_tready = 1'b1;
  logic [DW-1:0] tx_tdata;
  logic [KW-1:0] tx_tkeep;
  logic          tx_tlast;
  logic [31:0]   frames_sent, frames_dropped;

  lc_egress_frame_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .MAX_FRAMES (MAXF)
  ) dut (
    .clk_fabric     (clk_fabric),
    .rst_n          (rst_n),
    .fab_tvalid     (fab_tvalid),
    .fab_tready     (fab_tready),
    .fab_tdata      (fab_tdata),
    .fab_tkeep      (fab_tkeep),
    .fab_tlast      (fab_tlast),
    .fab_tuser      (fab_tuser),
    .tx_tvalid      (tx_tvalid),
    .tx_tready      (tx_tready),
    .tx_tdata       (tx_tdata),
    .tx_tkeep       (tx_tkeep),
    .tx_tlast       (tx_tlast),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
  );

  always #5 clk_fabric = ~clk_fabric;

  int unsigned   n_checks = 0, n_errors = 0;
  int unsigned   cyc = 0, last_cyc = 0, first_cyc = 0, words_out = 0;
  int unsigned   exp_sent = 0, exp_drop = 0, sb_frames = 0;
  bit            watch_first = 0, rdy_rand = 0;
  logic          rdy_fix = 1'b1;
  logic [36:0]   sb [$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_fabric);
    cyc++;
  end

  initial forever begin
    @(posedge clk_fabric);
    #1;
    tx_tready = rdy_rand ? ($urandom_range(0, 1) == 1) : rdy_fix;
  end

  // Transmit monitor: scoreboard compare and AXI hold-while-stalled check.
  initial begin
    logic        prev_stall;
    logic [36:0] w, e, prev_word;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk_fabric);
      w = {tx_tkeep, tx_tlast, tx_tdata};
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (watch_first && tx_tvalid) begin
          first_cyc   = cyc;
          watch_first = 0;
        end
        if (prev_stall) begin
          chk("hold_valid", tx_tvalid, 1);
          chk("hold_word", w, prev_word);
        end
        if (tx_tvalid && tx_tready) begin
          words_out++;
          chk("sb_pop_avail", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("tx_word", w, e);
            if (e[32]) sb_frames--;
          end
        end
        prev_stall = tx_tvalid && !tx_tready;
        prev_word  = w;
      end
    end
  end

  task automatic drive_word(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
    @(posedge clk_fabric);
    #1;
    fab_tvalid = 1'b1;
    fab_tdata  = d;
    fab_tkeep  = k;
    fab_tlast  = l;
    fab_tuser  = u;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_fabric);
      #1;
      fab_tvalid = 1'b0;
      fab_tlast  = 1'b0;
      fab_tuser  = 1'b0;
    end
  endtask

  task automatic send_frame(input int len, input bit bad, input bit keep_exp);
    logic [36:0] q [$];
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    for (int i = 0; i < len; i++) begin
      d = $urandom;
      l = (i == len - 1);
      k = l ? (4'hF >> $urandom_range(0, 3)) : 4'hF;
      drive_word(d, k, l, bad && l);
      q.push_back({k, l, d});
    end
    last_cyc = cyc;
    if (keep_exp) begin
      foreach (q[j]) sb.push_back(q[j]);
      sb_frames++;
      exp_sent++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk_fabric);
      n++;
    end
    chk("drain_done", sb.size(), 0);
    repeat (3) @(posedge clk_fabric);
    #1;
  endtask

  task automatic wait_space(input int len);
    int n = 0;
    while ((sb.size() + len > DEPTH - 4 || sb_frames >= MAXF - 2) && n < 20000) begin
      idle(1);
      n++;
    end
    chk("space_wait", n < 20000, 1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_fab_tready"}, fab_tready, 0);
    chk({p, "_tx_tvalid"}, tx_tvalid, 0);
    chk({p, "_tx_tdata"}, tx_tdata, 0);
    chk({p, "_tx_tkeep"}, tx_tkeep, 0);
    chk({p, "_tx_tlast"}, tx_tlast, 0);
    chk({p, "_sent"}, frames_sent, 0);
    chk({p, "_dropped"}, frames_dropped, 0);
  endtask

  task automatic check_counters(input string p);
    chk({p, "_sent"}, frames_sent, exp_sent);
    chk({p, "_dropped"}, frames_dropped, exp_drop);
  endtask

  initial begin
    int unsigned wo;
    repeat (2) @(negedge clk_fabric);
    check_zero("reset");
    @(posedge clk_fabric);
    #1 rst_n = 1'b1;
    idle(3);

    // Single good frame, first tx_tvalid two cycles after tlast.
    watch_first = 1;
    send_frame(16, 0, 1);
    idle(1);
    wait_drain(200);
    chk("t1_first_valid_cyc", first_cyc, last_cyc + 2);
    check_counters("t1");

    // Bad frame followed by a good one.
    send_frame(8, 1, 0);
    send_frame(4, 0, 1);
    idle(1);
    wait_drain(200);
    check_counters("t2");

    // Near-full buffer: second frame cannot fit.
    rdy_fix = 1'b0;
    idle(2);
    wo = words_out;
    send_frame(1000, 0, 1);
    send_frame(100, 0, 0);
    idle(5);
    chk("t3_dropped", frames_dropped, exp_drop);
    chk("t3_stalled_words", words_out - wo, 0);
    rdy_fix = 1'b1;
    wait_drain(3000);
    chk("t3_words_out", words_out - wo, 1000);
    check_counters("t3");

    // Descriptor exhaustion: 65th one-word frame is discarded.
    rdy_fix = 1'b0;
    idle(2);
    wo = words_out;
    for (int i = 0; i < 64; i++) send_frame(1, 0, 1);
    send_frame(1, 0, 0);
    idle(4);
    chk("t4_dropped", frames_dropped, exp_drop);
    rdy_fix = 1'b1;
    wait_drain(1000);
    chk("t4_words_out", words_out - wo, 64);
    check_counters("t4");

    // Random lengths, random bad frames, random downstream ready.
    rdy_rand = 1;
    for (int i = 0; i < 200; i++) begin
      int  len;
      bit  bad;
      len = $urandom_range(1, 40);
      bad = ($urandom_range(0, 9) == 0);
      wait_space(len);
      send_frame(len, bad, !bad);
      idle($urandom_range(0, 2));
    end
    idle(1);
    wait_drain(40000);
    rdy_rand = 0;
    rdy_fix  = 1'b1;
    idle(2);
    check_counters("t5");

    // Reset in the middle of a frame.
    for (int i = 0; i < 5; i++) drive_word($urandom, 4'hF, 1'b0, 1'b0);
    #2;
    rst_n      = 1'b0;
    fab_tvalid = 1'b0;
    @(negedge clk_fabric);
    check_zero("t6_rst");
    exp_sent = 0;
    exp_drop = 0;
    repeat (2) @(posedge clk_fabric);
    #1 rst_n = 1'b1;
    idle(3);
    check_counters("t6_post_rst");
    send_frame(3, 0, 1);
    idle(1);
    wait_drain(200);
    check_counters("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
